// File: rtl/adc_scan_reader.sv
// adc_scan_reader: periodic scanner for a 12-bit serial ADC with a pipelined
// channel-config word. The result clocked out in one frame belongs to the
// channel configured in the previous frame.
// Optional feature: define ADC_SCAN_BANK_EN to add the per-channel result bank.
module adc_scan_reader #(
    parameter int NUM_CH  = 8,
    parameter int CLK_DIV = 80,
    parameter int TCONV   = 100,
    parameter int PERIOD  = 4000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              uni,
    output logic              convst,
    output logic              sck,
    output logic              sdi,
    input  logic              sdo,
    output logic [11:0]       data,
    output logic [2:0]        data_ch,
    output logic              data_valid,
    output logic              overrun
`ifdef ADC_SCAN_BANK_EN
    ,
    output logic [NUM_CH*12-1:0] bank
`endif
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int TW = $clog2(TCONV + 1);
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST     = CW'(PERIOD - 1);
    localparam logic [TW-1:0] TMR_CONV_END = TW'(1);
    localparam logic [TW-1:0] TMR_WAIT_END = TW'(TCONV - 1);
    // first sdi bit is loaded one sck phase ahead of the first sck rise
    localparam logic [TW-1:0] TMR_SDI      = TW'((TCONV - CLK_DIV >= 2) ? (TCONV - CLK_DIV - 1) : 1);
    localparam logic [PW-1:0] PH_LAST      = PW'(CLK_DIV - 1);
    localparam logic [2:0]    CH_LAST      = 3'(NUM_CH - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CONV  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [TW-1:0] tmr_r;
    logic [PW-1:0] ph_r;
    logic [3:0]    bit_r;
    logic [11:0]   sr_r;
    logic [2:0]    cur_ch_r;
    logic [2:0]    rd_ch_r;
    logic          prime_r;
    logic          frame_vld_r;
    logic          tick_s, start_s, rise_s, fall_s, busy_s;
    logic [5:0]    cfg_s;

    // Next enabled channel strictly above cur, wrapping to the lowest set bit.
    function automatic logic [2:0] next_ch(input logic [NUM_CH-1:0] mask, input logic [2:0] cur);
        logic [2:0] res;
        logic       found;
        int         idx;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(cur) + k) % NUM_CH;
            if (!found && mask[idx]) begin
                res   = 3'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // Config word shifted out MSB first: {1, c[0], c[2:1], uni, 0}.
    function automatic logic [5:0] cfg_word(input logic [2:0] ch, input logic u);
        return {1'b1, ch[0], ch[2], ch[1], u, 1'b0};
    endfunction

    assign tick_s = (cnt_r == CNT_LAST);
    assign busy_s = (state_r == ST_CONV) || (state_r == ST_WAIT) || (state_r == ST_SHIFT);
    assign cfg_s  = cfg_word(cur_ch_r, uni);

    // Free-running conversion period counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        cnt_r <= {CW{1'b0}};
        else if (tick_s) cnt_r <= {CW{1'b0}};
        else             cnt_r <= cnt_r + CW'(1);
    end

    // Frame state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_r <= ST_IDLE;
        else      state_r <= state_nxt_s;
    end

    // Next-state logic plus start / sck-edge strobes.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        rise_s      = 1'b0;
        fall_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (tick_s && enable && (|ch_mask)) begin
                    state_nxt_s = ST_CONV;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (tmr_r == TMR_CONV_END) state_nxt_s = ST_WAIT;
                else                       state_nxt_s = ST_CONV;
            end
            ST_WAIT: begin
                if (tmr_r == TMR_WAIT_END) begin
                    state_nxt_s = ST_SHIFT;
                    rise_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_SHIFT: begin
                if (ph_r == PH_LAST) begin
                    if (sck) begin
                        fall_s = 1'b1;
                        if (bit_r == 4'd11) state_nxt_s = ST_DONE;
                        else                state_nxt_s = ST_SHIFT;
                    end else begin
                        rise_s      = 1'b1;
                        state_nxt_s = ST_SHIFT;
                    end
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Frame datapath: ADC pins, shift register, channel pipeline and results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            convst      <= 1'b0;
            sck         <= 1'b0;
            sdi         <= 1'b0;
            data        <= 12'd0;
            data_ch     <= 3'd0;
            data_valid  <= 1'b0;
            overrun     <= 1'b0;
            tmr_r       <= {TW{1'b0}};
            ph_r        <= {PW{1'b0}};
            bit_r       <= 4'd0;
            sr_r        <= 12'd0;
            cur_ch_r    <= CH_LAST;
            rd_ch_r     <= 3'd0;
            prime_r     <= 1'b0;
            frame_vld_r <= 1'b0;
`ifdef ADC_SCAN_BANK_EN
            bank        <= {(NUM_CH*12){1'b0}};
`endif
        end else begin
            data_valid <= 1'b0;
            if (tick_s && busy_s) overrun <= 1'b1;
            // a skipped tick or a disabled scan breaks the config pipeline
            if (!enable || (state_r == ST_IDLE && tick_s && !start_s)) prime_r <= 1'b0;

            if (start_s) begin
                convst      <= 1'b1;
                tmr_r       <= {TW{1'b0}};
                rd_ch_r     <= cur_ch_r;
                cur_ch_r    <= next_ch(ch_mask, cur_ch_r);
                frame_vld_r <= prime_r;
            end

            if (state_r == ST_CONV || state_r == ST_WAIT) begin
                tmr_r <= tmr_r + TW'(1);
                if (state_r == ST_CONV && tmr_r == TMR_CONV_END) convst <= 1'b0;
                if (tmr_r == TMR_SDI) sdi <= cfg_s[5];
            end

            if (rise_s) begin
                sck  <= 1'b1;
                sr_r <= {sr_r[10:0], sdo};
                ph_r <= {PW{1'b0}};
                if (state_r == ST_SHIFT) bit_r <= bit_r + 4'd1;
                else                     bit_r <= 4'd0;
            end else if (fall_s) begin
                sck  <= 1'b0;
                ph_r <= {PW{1'b0}};
                if (bit_r < 4'd5) sdi <= cfg_s[3'd4 - bit_r[2:0]];
                else              sdi <= 1'b0;
            end else if (state_r == ST_SHIFT) begin
                ph_r <= ph_r + PW'(1);
            end

            if (state_r == ST_DONE) begin
                data       <= sr_r;
                data_ch    <= rd_ch_r;
                data_valid <= frame_vld_r;
                prime_r    <= enable;
`ifdef ADC_SCAN_BANK_EN
                if (frame_vld_r) bank[12*int'(rd_ch_r) +: 12] <= sr_r;
`endif
            end
        end
    end

endmodule

// File: tb/tb_adc_scan_reader.sv
// Scoreboard bench for adc_scan_reader: an ADC model decodes the sdi config
// word and answers 12'hA50+channel one frame later; expected results are
// queued by the stimulus and popped by a monitor on every data_valid.
module tb_adc_scan_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst2, enable, uni;
    logic [7:0]  ch_mask;
    logic        sdo = 1'b0;
    logic        convst, sck, sdi, data_valid, overrun;
    logic [11:0] data;
    logic [2:0]  data_ch;
    logic        convst2, sck2, sdi2, data_valid2, overrun2;
    logic [11:0] data2;
    logic [2:0]  data_ch2;
`ifdef ADC_SCAN_BANK_EN
    logic [95:0] bank, bank2;
`endif

    int n_vec = 0;
    int n_err = 0;

    adc_scan_reader #(.NUM_CH(8), .CLK_DIV(4), .TCONV(10), .PERIOD(300)) dut (
        .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask), .uni(uni),
        .convst(convst), .sck(sck), .sdi(sdi), .sdo(sdo),
        .data(data), .data_ch(data_ch), .data_valid(data_valid), .overrun(overrun)
`ifdef ADC_SCAN_BANK_EN
        , .bank(bank)
`endif
    );

    adc_scan_reader #(.NUM_CH(8), .CLK_DIV(4), .TCONV(10), .PERIOD(60)) dut_ovr (
        .clk(clk), .rst(rst2), .enable(1'b1), .ch_mask(8'h01), .uni(1'b0),
        .convst(convst2), .sck(sck2), .sdi(sdi2), .sdo(1'b0),
        .data(data2), .data_ch(data_ch2), .data_valid(data_valid2), .overrun(overrun2)
`ifdef ADC_SCAN_BANK_EN
        , .bank(bank2)
`endif
    );

    // ---------------- ADC model ----------------
    logic [11:0] adc_word = 12'd0;
    logic [5:0]  cfg_cap = 6'd0;
    int          prev_ch = 0, last_ch = 0, rise_cnt = 0, frames = 0, hi_bad = 0, starts2 = 0;
    time         t_rise = 0;

    always @(posedge convst) begin
        frames++;
        prev_ch  = last_ch;
        adc_word = 12'hA50 + 12'(prev_ch);
        sdo      = adc_word[11];
        rise_cnt = 0;
    end

    always @(posedge sck) begin
        if (rise_cnt < 6) cfg_cap = {cfg_cap[4:0], sdi};
        rise_cnt++;
        if (rise_cnt == 6) last_ch = int'({cfg_cap[3], cfg_cap[2], cfg_cap[4]});
        t_rise = $time;
    end

    always @(negedge sck) begin
        adc_word = {adc_word[10:0], 1'b0};
        sdo      = adc_word[11];
        if (rst && ($time - t_rise != 40)) hi_bad++;
    end

    always @(posedge convst2) starts2++;

    // ---------------- scoreboard ----------------
    typedef struct packed { logic [2:0] ch; logic [11:0] d; } exp_t;
    exp_t q[$];
    exp_t e;

    always @(negedge clk) begin
        if (rst && data_valid) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid got ch=%0d data=%h required no valid", data_ch, data);
            end else begin
                e = q.pop_front();
                if (data !== e.d || data_ch !== e.ch) begin
                    n_err++;
                    $display("FAIL valid_result got ch=%0d data=%h required ch=%0d data=%h",
                             data_ch, data, e.ch, e.d);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h required=%0h", name, got, exp);
        end
    endtask

    task automatic push(input int ch);
        exp_t x;
        x.ch = 3'(ch);
        x.d  = 12'hA50 + 12'(ch);
        q.push_back(x);
    endtask

    task automatic wait_start();
        int f0;
        int k;
        f0 = frames;
        k  = 0;
        while (frames == f0 && k < 700) begin
            @(posedge clk);
            k++;
        end
        chk("frame_start_in_budget", 32'(frames != f0), 32'd1);
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) begin
            wait_start();
            repeat (130) @(posedge clk);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int f0;
        int k;
`ifdef ADC_SCAN_BANK_EN
        logic [95:0] exp_bank;
`endif
        rst = 1'b0; rst2 = 1'b0; enable = 1'b1; uni = 1'b1; ch_mask = 8'h05;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_convst", 32'(convst), 32'd0);
        chk("rst_sck", 32'(sck), 32'd0);
        chk("rst_sdi", 32'(sdi), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_data_ch", 32'(data_ch), 32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        rst = 1'b1; rst2 = 1'b1;

        // overrun instance: PERIOD 60, frame ~103 cycles
        repeat (62) @(posedge clk); #1;
        chk("ovr_after_tick1", 32'(overrun2), 32'd0);
        repeat (63) @(posedge clk); #1;
        chk("ovr_after_tick2", 32'(overrun2), 32'd1);
        repeat (45) @(posedge clk); #1;
        chk("ovr_starts_170", 32'(starts2), 32'd1);
        repeat (30) @(posedge clk); #1;
        chk("ovr_starts_200", 32'(starts2), 32'd2);

        // mask 05: configs 0,2,0,2,0 -> results ch0,ch2,ch0,ch2 (first frame silent)
        push(0); push(2); push(0); push(2);
        run_frames(5);
        chk("maskA_queue_empty", 32'(q.size()), 32'd0);
        chk("maskA_overrun", 32'(overrun), 32'd0);
`ifdef ADC_SCAN_BANK_EN
        exp_bank = 96'd0;
        exp_bank[11:0]  = 12'hA50;
        exp_bank[35:24] = 12'hA52;
        n_vec++;
        if (bank !== exp_bank) begin
            n_err++;
            $display("FAIL bank got=%h required=%h", bank, exp_bank);
        end
`endif

        // current channel (0) dropped: next frames configure ch3
        ch_mask = 8'h08;
        push(0); push(3);
        run_frames(2);
        chk("ch3_queue_empty", 32'(q.size()), 32'd0);
        chk("sdi_cfg_ch3", 32'(cfg_cap), 32'b110110);
        chk("sck_rises_per_frame", 32'(rise_cnt), 32'd12);
        chk("sck_high_time", 32'(hi_bad), 32'd0);

        // empty mask: no conversions for 3 periods
        ch_mask = 8'h00;
        f0 = frames;
        repeat (900) @(posedge clk);
        chk("mask0_no_convst", 32'(frames - f0), 32'd0);

        // mask 80: first frame silent, then ch7 results
        ch_mask = 8'h80;
        push(7); push(7);
        run_frames(3);
        chk("ch7_queue_empty", 32'(q.size()), 32'd0);

        // enable falls mid-frame: that frame still reports
        push(7);
        wait_start();
        repeat (20) @(posedge clk);
        enable = 1'b0;
        repeat (130) @(posedge clk);
        chk("enable_drop_valid", 32'(q.size()), 32'd0);
        repeat (300) @(posedge clk);
        enable = 1'b1;
        push(7);
        run_frames(2);
        chk("enable_rise_queue_empty", 32'(q.size()), 32'd0);

        // reset during SHIFT
        wait_start();
        k = 0;
        while (sck !== 1'b1 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("reached_shift", 32'(sck), 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_convst", 32'(convst), 32'd0);
        chk("midrst_sck", 32'(sck), 32'd0);
        chk("midrst_sdi", 32'(sdi), 32'd0);
        chk("midrst_data", 32'(data), 32'd0);
        chk("midrst_data_ch", 32'(data_ch), 32'd0);
        chk("midrst_valid", 32'(data_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        push(7);
        run_frames(2);
        chk("post_rst_queue_empty", 32'(q.size()), 32'd0);
        chk("final_overrun", 32'(overrun), 32'd0);
        chk("ovr_sticky", 32'(overrun2), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
